// File: rtl/syn_exec_ctrl.sv
// rtl/syn_exec_ctrl.sv - CPU execution controller: run/pause/step/halt, breakpoint stop, saturating stats
module syn_exec_ctrl #(
    parameter int CntWidth = 32,
    parameter int AutoRun  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                pause,
    input  logic                step,
    input  logic                clr_stats,
    input  logic                bp_en,
    input  logic [31:0]         bp_addr,
    input  logic [31:0]         pc_dbg,
    input  logic                cpu_halt,
    input  logic                cpu_jumped,
    input  logic                cpu_is_branch,
    input  logic                cpu_branched,
    output logic                cpu_en,
    output logic [1:0]          state,
    output logic                bp_hit,
    output logic [CntWidth-1:0] cyc_cnt,
    output logic [CntWidth-1:0] jmp_cnt,
    output logic [CntWidth-1:0] br_cnt,
    output logic [CntWidth-1:0] brt_cnt
);

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam state_e              RstState = (AutoRun != 0) ? ST_RUN : ST_PAUSED;
    localparam logic [CntWidth-1:0] CntMax   = '1;

    state_e              state_q, state_d;
    logic                bp_hit_q, bp_hit_d;
    logic                skip_bp_q, skip_bp_d;
    logic [CntWidth-1:0] cyc_q, cyc_d, jmp_q, jmp_d, br_q, br_d, brt_q, brt_d;
    logic                bp_block;
    logic                exec;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v, input logic inc);
        sat_inc = (inc && (v != CntMax)) ? v + 1'b1 : v;
    endfunction

    // rst_n gating keeps the CPU stopped during reset even when AutoRun parks us in RUN
    always_comb begin
        bp_block = bp_en && (pc_dbg == bp_addr) && !skip_bp_q && (state_q == ST_RUN);
        cpu_en   = rst_n && ((state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_block));
        exec     = cpu_en && !cpu_halt;
    end

    always_comb begin
        state_d   = state_q;
        bp_hit_d  = bp_hit_q;
        skip_bp_d = skip_bp_q;
        unique case (state_q)
            ST_PAUSED: begin
                if (cpu_halt) begin
                    state_d = ST_HALTED;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (step || run) begin
                    state_d   = step ? ST_STEP : ST_RUN;
                    bp_hit_d  = 1'b0;
                    skip_bp_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (cpu_halt) begin
                    state_d = ST_HALTED;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (bp_block) begin
                    state_d  = ST_PAUSED;
                    bp_hit_d = 1'b1;
                end
            end
            ST_STEP:   state_d = cpu_halt ? ST_HALTED : ST_PAUSED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_HALTED;
        endcase
        // skip_bp only survives until the resumed instruction has actually been issued
        if (state_q != ST_PAUSED && cpu_en) begin
            skip_bp_d = 1'b0;
        end
    end

    always_comb begin
        cyc_d = sat_inc(cyc_q, exec);
        jmp_d = sat_inc(jmp_q, exec && cpu_jumped);
        br_d  = sat_inc(br_q,  exec && cpu_is_branch);
        brt_d = sat_inc(brt_q, exec && cpu_branched);
        if (clr_stats) begin
            cyc_d = '0;
            jmp_d = '0;
            br_d  = '0;
            brt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RstState;
            bp_hit_q  <= 1'b0;
            skip_bp_q <= 1'b1;
            cyc_q     <= '0;
            jmp_q     <= '0;
            br_q      <= '0;
            brt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bp_hit_q  <= bp_hit_d;
            skip_bp_q <= skip_bp_d;
            cyc_q     <= cyc_d;
            jmp_q     <= jmp_d;
            br_q      <= br_d;
            brt_q     <= brt_d;
        end
    end

    assign state   = state_q;
    assign bp_hit  = bp_hit_q;
    assign cyc_cnt = cyc_q;
    assign jmp_cnt = jmp_q;
    assign br_cnt  = br_q;
    assign brt_cnt = brt_q;

endmodule

// File: tb/tb_syn_exec_ctrl.sv
// tb/tb_syn_exec_ctrl.sv - self-checking bench for syn_exec_ctrl with a behavioural reference model
module tb_syn_exec_ctrl;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, run, pause, step, clr_stats, bp_en;
    logic [31:0]   bp_addr, pc_dbg;
    logic          cpu_halt, cpu_jumped, cpu_is_branch, cpu_branched;
    logic          cpu_en, bp_hit;
    logic [1:0]    state;
    logic [CW-1:0] cyc_cnt, jmp_cnt, br_cnt, brt_cnt;

    syn_exec_ctrl #(.CntWidth(CW), .AutoRun(0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .pause(pause), .step(step), .clr_stats(clr_stats),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc_dbg(pc_dbg), .cpu_halt(cpu_halt),
        .cpu_jumped(cpu_jumped), .cpu_is_branch(cpu_is_branch), .cpu_branched(cpu_branched),
        .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit),
        .cyc_cnt(cyc_cnt), .jmp_cnt(jmp_cnt), .br_cnt(br_cnt), .brt_cnt(brt_cnt)
    );

    int total = 0;
    int bad   = 0;

    // reference model: 0 paused, 1 run, 2 step, 3 halted
    int m_state, m_cyc, m_jmp, m_br, m_brt;
    bit m_bp_hit, m_skip;
    bit exp_en, act_en;
    logic [31:0] pc;

    function automatic bit model_en();
        if (m_state == 2) return 1'b1;
        if (m_state == 1) return !(bp_en && pc_dbg == bp_addr && !m_skip);
        return 1'b0;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_bp_hit = 0; m_skip = 1;
        m_cyc = 0; m_jmp = 0; m_br = 0; m_brt = 0;
    endfunction

    function automatic void model_update();
        bit en, resumed;
        int ns;
        en = model_en();
        resumed = 0;
        ns = m_state;
        if (clr_stats) begin
            m_cyc = 0; m_jmp = 0; m_br = 0; m_brt = 0;
        end else if (en && !cpu_halt) begin
            m_cyc = sat(m_cyc);
            if (cpu_jumped)    m_jmp = sat(m_jmp);
            if (cpu_is_branch) m_br  = sat(m_br);
            if (cpu_branched)  m_brt = sat(m_brt);
        end
        case (m_state)
            0: if (cpu_halt) ns = 3;
               else if (pause) ns = 0;
               else if (step) begin ns = 2; resumed = 1; end
               else if (run)  begin ns = 1; resumed = 1; end
            1: if (cpu_halt) ns = 3;
               else if (pause) ns = 0;
               else if (!en) begin ns = 0; m_bp_hit = 1; end
            2: ns = cpu_halt ? 3 : 0;
            default: ns = 3;
        endcase
        if (resumed) begin
            m_skip = 1; m_bp_hit = 0;
        end else if (en) begin
            m_skip = 0;
        end
        m_state = ns;
    endfunction

    task automatic clear_inputs();
        run = 0; pause = 0; step = 0; clr_stats = 0; bp_en = 0; bp_addr = 32'h10; pc_dbg = 0;
        cpu_halt = 0; cpu_jumped = 0; cpu_is_branch = 0; cpu_branched = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic tick();
        @(negedge clk);
        exp_en = model_en();
        act_en = cpu_en;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        #2;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en got=%b want=0", cpu_en); end
        total++; if (bp_hit !== 1'b0) begin bad++; $display("FAIL reset_bp_hit got=%b want=0", bp_hit); end
        total++; if ({cyc_cnt, jmp_cnt, br_cnt, brt_cnt} !== 16'h0) begin bad++;
            $display("FAIL reset_counters got=%h want=0", {cyc_cnt, jmp_cnt, br_cnt, brt_cnt}); end
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_single_step();
        do_reset();
        step = 1; tick(); step = 0;
        total++; if (state !== 2'd2) begin bad++; $display("FAIL step_state got=%0d want=2", state); end
        total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL step_cpu_en got=%b want=1", cpu_en); end
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL step_back_paused got=%0d want=0", state); end
        total++; if (cyc_cnt !== 4'd1) begin bad++; $display("FAIL step_cyc got=%0d want=1", cyc_cnt); end
        tick();
        total++; if (act_en !== 1'b0) begin bad++; $display("FAIL step_one_cycle got=%b want=0", act_en); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        bp_en = 1; bp_addr = 32'h10; pc = 0; pc_dbg = pc;
        run = 1; tick(); run = 0;
        for (int i = 0; i < 20 && state == 2'd1; i++) begin
            tick();
            if (act_en) pc = pc + 4;
            pc_dbg = pc;
        end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL bp_state got=%0d want=0", state); end
        total++; if (bp_hit !== 1'b1) begin bad++; $display("FAIL bp_hit got=%b want=1", bp_hit); end
        total++; if (cyc_cnt !== 4'd4) begin bad++; $display("FAIL bp_cyc got=%0d want=4", cyc_cnt); end
        total++; if (pc_dbg !== 32'h10 || cpu_en !== 1'b0) begin bad++;
            $display("FAIL bp_stop_pc got=%h/%b want=10/0", pc_dbg, cpu_en); end
        run = 1; tick(); run = 0;
        total++; if (bp_hit !== 1'b0) begin bad++; $display("FAIL bp_hit_clear got=%b want=0", bp_hit); end
        tick();
        total++; if (act_en !== 1'b1) begin bad++; $display("FAIL bp_resume_en got=%b want=1", act_en); end
        total++; if (cyc_cnt !== 4'd5) begin bad++; $display("FAIL bp_resume_cyc got=%0d want=5", cyc_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1; tick(); run = 0;
        tick(); tick();
        cpu_halt = 1; tick(); cpu_halt = 0;
        total++; if (state !== 2'd3) begin bad++; $display("FAIL halt_state got=%0d want=3", state); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL halt_cpu_en got=%b want=0", cpu_en); end
        run = 1; tick(); run = 0;
        step = 1; tick(); step = 0;
        tick();
        total++; if (state !== 2'd3) begin bad++; $display("FAIL halt_sticky got=%0d want=3", state); end
        total++; if (cyc_cnt !== 4'd2) begin bad++; $display("FAIL halt_frozen got=%0d want=2", cyc_cnt); end
    endtask

    task automatic test_priority();
        do_reset();
        run = 1; step = 1; tick(); run = 0; step = 0;
        total++; if (state !== 2'd2) begin bad++; $display("FAIL prio_step got=%0d want=2", state); end
        do_reset();
        run = 1; tick(); run = 0;
        pause = 1; cpu_halt = 1; tick(); pause = 0; cpu_halt = 0;
        total++; if (state !== 2'd3) begin bad++; $display("FAIL prio_halt got=%0d want=3", state); end
    endtask

    task automatic test_counters();
        do_reset();
        run = 1; tick(); run = 0;
        cpu_branched = 1;
        repeat (20) tick();
        total++; if (cyc_cnt !== 4'hF) begin bad++; $display("FAIL sat_cyc got=%h want=f", cyc_cnt); end
        total++; if (brt_cnt !== 4'hF) begin bad++; $display("FAIL sat_brt got=%h want=f", brt_cnt); end
        total++; if (br_cnt !== 4'h0 || jmp_cnt !== 4'h0) begin bad++;
            $display("FAIL sat_other got=%h/%h want=0/0", br_cnt, jmp_cnt); end
        clr_stats = 1; tick(); clr_stats = 0; cpu_branched = 0;
        total++; if (act_en !== 1'b1) begin bad++; $display("FAIL clr_en got=%b want=1", act_en); end
        total++; if ({cyc_cnt, jmp_cnt, br_cnt, brt_cnt} !== 16'h0) begin bad++;
            $display("FAIL clr_counters got=%h want=0", {cyc_cnt, jmp_cnt, br_cnt, brt_cnt}); end
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1; tick(); run = 0;
        tick(); tick(); tick();
        total++; if (cyc_cnt !== 4'd3 || cpu_en !== 1'b1) begin bad++;
            $display("FAIL arst_pre got=%0d/%b want=3/1", cyc_cnt, cpu_en); end
        #2 rst_n = 0;
        #1;
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL arst_cpu_en got=%b want=0", cpu_en); end
        total++; if (cyc_cnt !== 4'd0) begin bad++; $display("FAIL arst_cyc got=%0d want=0", cyc_cnt); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL arst_state got=%0d want=0", state); end
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 59) do_reset();
            run           = ($urandom_range(0, 5) == 0);
            pause         = ($urandom_range(0, 9) == 0);
            step          = ($urandom_range(0, 7) == 0);
            clr_stats     = ($urandom_range(0, 24) == 0);
            cpu_halt      = ($urandom_range(0, 49) == 0);
            bp_en         = $urandom_range(0, 1);
            cpu_jumped    = $urandom_range(0, 1);
            cpu_is_branch = $urandom_range(0, 1);
            cpu_branched  = cpu_is_branch & $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0: pc_dbg = bp_addr;
                1: pc_dbg = bp_addr + 4;
                default: pc_dbg = $urandom;
            endcase
            tick();
            total++; if (act_en !== exp_en) begin bad++; $display("FAIL rnd_cpu_en i=%0d got=%b want=%b", i, act_en, exp_en); end
            total++; if (state !== m_state[1:0]) begin bad++; $display("FAIL rnd_state i=%0d got=%0d want=%0d", i, state, m_state); end
            total++; if (bp_hit !== m_bp_hit) begin bad++; $display("FAIL rnd_bp_hit i=%0d got=%b want=%b", i, bp_hit, m_bp_hit); end
            total++; if ({cyc_cnt, jmp_cnt, br_cnt, brt_cnt} !== {m_cyc[3:0], m_jmp[3:0], m_br[3:0], m_brt[3:0]}) begin bad++;
                $display("FAIL rnd_counters i=%0d got=%h want=%h", i, {cyc_cnt, jmp_cnt, br_cnt, brt_cnt},
                         {m_cyc[3:0], m_jmp[3:0], m_br[3:0], m_brt[3:0]}); end
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_breakpoint();
        test_halt();
        test_priority();
        test_counters();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
